// File: rtl/sfx_pkg.sv
// Shared types and helpers for the sound-effect player.
package sfx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPlay
  } state_e;

  localparam int unsigned VOL_W    = 3;
  localparam int unsigned MaxPackW = 8 * 32;

  // Extract slice idx (width bits) of a packed per-clip address vector.
  function automatic logic [31:0] clip_addr(input logic [MaxPackW-1:0] vec,
                                            input int unsigned        idx,
                                            input int unsigned        width);
    return 32'(vec >> (idx * width)) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/sfx_trigger_arb.sv
// Rising-edge detect on the trigger inputs with lowest-index-wins arbitration.
module sfx_trigger_arb #(
  parameter int unsigned NUM_CLIPS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CLIPS-1:0] trigger_i,
  output logic                 req_o,
  output logic [2:0]           req_idx_o
);

  logic [NUM_CLIPS-1:0] trig_q;
  logic [NUM_CLIPS-1:0] rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q <= '0;
    end else begin
      trig_q <= trigger_i;
    end
  end

  assign rise  = trigger_i & ~trig_q;
  assign req_o = |rise;

  always_comb begin
    req_idx_o = '0;
    for (int i = NUM_CLIPS - 1; i >= 0; i--) begin
      if (rise[i]) req_idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/sfx_player.sv
// Multi-clip sound-effect player: ROM fetch, sample repetition, volume shift, loop and stop.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int unsigned NUM_CLIPS = 4,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned REPEAT    = 2,
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_BASE = {11'd300, 11'd200, 11'd100, 11'd0},
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_LAST = {11'd399, 11'd299, 11'd199, 11'd99}
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_CLIPS-1:0]  trigger,
  input  logic                  loop_en,
  input  logic                  stop,
  input  logic [VOL_W-1:0]      vol,
  input  logic [1:0]            chan_en,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [2*SAMPLE_W-1:0] rom_q,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic [31:0]           left_channel_audio_out,
  output logic [31:0]           right_channel_audio_out,
  output logic                  busy,
  output logic [2:0]            active_clip,
  output logic                  done
);

  localparam logic [MaxPackW-1:0] BaseVec = MaxPackW'(CLIP_BASE);
  localparam logic [MaxPackW-1:0] LastVec = MaxPackW'(CLIP_LAST);
  localparam logic [1:0]          RepLast = 2'(REPEAT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
  logic [2:0]          clip_q, clip_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic                loop_q, loop_d;
  logic                fetch_q, fetch_d;
  logic                half_q, half_d;
  logic [1:0]          rep_q, rep_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [31:0]         left_q, left_d;
  logic [31:0]         right_q, right_d;
  logic                done_q, done_d;

  logic                req;
  logic [2:0]          req_idx;
  logic [ADDR_W-1:0]   req_base, cur_base, cur_last;
  logic                restart, load;
  logic [SAMPLE_W-1:0] load_s;

  sfx_trigger_arb #(
    .NUM_CLIPS(NUM_CLIPS)
  ) u_arb (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .trigger_i(trigger),
    .req_o    (req),
    .req_idx_o(req_idx)
  );

  assign req_base = ADDR_W'(clip_addr(BaseVec, 32'(req_idx), ADDR_W));
  assign cur_base = ADDR_W'(clip_addr(BaseVec, 32'(clip_q), ADDR_W));
  assign cur_last = ADDR_W'(clip_addr(LastVec, 32'(clip_q), ADDR_W));

  function automatic logic [31:0] fmt(input logic [SAMPLE_W-1:0] s, input logic [VOL_W-1:0] v);
    logic signed [SAMPLE_W-1:0] sh;
    sh = $signed(s) >>> v;
    return {sh, {(32 - SAMPLE_W){1'b0}}};
  endfunction

  assign write_audio_out = (state_q == StPlay) && audio_out_allowed;

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    clip_d      = clip_q;
    vol_d       = vol_q;
    loop_d      = loop_q;
    fetch_d     = fetch_q;
    half_d      = half_q;
    rep_d       = rep_q;
    hold_d      = hold_q;
    left_d      = left_q;
    right_d     = right_q;
    done_d      = 1'b0;
    restart     = 1'b0;
    load        = 1'b0;
    load_s      = '0;

    unique case (state_q)
      StIdle: restart = req;
      StFetch: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (req && (req_idx <= clip_q)) begin
          restart = 1'b1;
        end else if (fetch_q) begin
          state_d = StPlay;
          hold_d  = rom_q[SAMPLE_W-1:0];
          half_d  = 1'b0;
          rep_d   = '0;
          load    = 1'b1;
          load_s  = rom_q[2*SAMPLE_W-1:SAMPLE_W];
        end else begin
          fetch_d = 1'b1;
        end
      end
      StPlay: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (req && (req_idx <= clip_q)) begin
          restart = 1'b1;
        end else if (write_audio_out) begin
          if (rep_q != RepLast) begin
            rep_d = rep_q + 2'd1;
          end else if (!half_q) begin
            rep_d  = '0;
            half_d = 1'b1;
            load   = 1'b1;
            load_s = hold_q;
          end else begin
            state_d = StFetch;
            fetch_d = 1'b0;
            if (word_addr_q != cur_last) begin
              word_addr_d = word_addr_q + ADDR_W'(1);
            end else if (loop_q) begin
              word_addr_d = cur_base;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (restart) begin
      state_d     = StFetch;
      fetch_d     = 1'b0;
      clip_d      = req_idx;
      vol_d       = vol;
      loop_d      = loop_en;
      word_addr_d = req_base;
    end

    // Output registers always hold the sample of the slot currently being presented.
    if (load) begin
      left_d  = chan_en[0] ? fmt(load_s, vol_q) : '0;
      right_d = chan_en[1] ? fmt(load_s, vol_q) : '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= StIdle;
      word_addr_q <= '0;
      clip_q      <= '0;
      vol_q       <= '0;
      loop_q      <= 1'b0;
      fetch_q     <= 1'b0;
      half_q      <= 1'b0;
      rep_q       <= '0;
      hold_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      clip_q      <= clip_d;
      vol_q       <= vol_d;
      loop_q      <= loop_d;
      fetch_q     <= fetch_d;
      half_q      <= half_d;
      rep_q       <= rep_d;
      hold_q      <= hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr                = word_addr_q;
  assign left_channel_audio_out  = left_q;
  assign right_channel_audio_out = right_q;
  assign busy                    = (state_q != StIdle);
  assign active_clip             = clip_q;
  assign done                    = done_q;

endmodule
